j1_dbus_wb_bridge: RTL and testbench
====================================

// Module: j1_dbus_wb_bridge
// PURPOSE
//  Sits directly downstream of the J1 core data bus (if_dbus side). Converts the core's single-cycle
//  re/we strobes into Wishbone B4 classic cycles toward I/O peripherals.
//  It stalls the core until ack, err or timeout, then returns read data and a one-cycle error flag.
//  It is a single master and supports one outstanding transfer.
// PARAMETERS
//  AW       16      address width (word address, same as core dbus.adr)
//  DW       16      data width
//  TIMEOUT  255     max cycles in BUS before forced abort (1..2**TW-1)
//  TW       8       timeout counter width
// PORTS
//  clk        in   1   single clock, all logic on posedge
//  reset      in   1   synchronous, active-high
//  dbus_adr   in   AW  core address, sampled on request accept
//  dbus_dat_o in   DW  core write data
//  dbus_re    in   1   read request
//  dbus_we    in   1   write request
//  dbus_dat_i out  DW  read data to core, valid while in RESP
//  stall      out  1   core must hold request/pipeline while high
//  bus_err    out  1   one-cycle pulse in RESP when access ended by wb_err or timeout
//  wb_cyc_o   out  1   Wishbone cycle
//  wb_stb_o   out  1   Wishbone strobe (== wb_cyc_o, classic)
//  wb_we_o    out  1   Wishbone write enable
//  wb_adr_o   out  AW  Wishbone address (registered)
//  wb_dat_o   out  DW  Wishbone write data (registered)
//  wb_dat_i   in   DW  Wishbone read data
//  wb_ack_i   in   1   Wishbone acknowledge
//  wb_err_i   in   1   Wishbone error
// BEHAVIOUR
//  - FSM states: IDLE, BUS, RESP. Reset -> IDLE. All outputs are 0 at reset (dbus_dat_i=0, stall=0, bus_err=0).
//  - IDLE:
//    - On (dbus_re|dbus_we), register adr/dat/we, clear the timeout counter, and go to BUS.
//    - If both re and we are high, the access is a write.
//    - stall = (dbus_re|dbus_we) combinationally in IDLE.
//  - BUS: wb_cyc_o=wb_stb_o=1, stall=1, and the counter increments every cycle.
//    - wb_ack_i: on a read, latch wb_dat_i into the rdata register. Go to RESP with err=0.
//    - wb_err_i, or counter==TIMEOUT: rdata<=ERR_DATA ('1) on a read. Go to RESP with err=1.
//    - Priority: ack > err > timeout in the same cycle.
//  - RESP: cyc/stb=0, stall=0, dbus_dat_i=rdata, bus_err=err. Unconditionally go to IDLE next cycle.
//    - Request lines seen in RESP belong to the completing access and are ignored.
//  - Latency: request in cycle 0, cyc asserted in cycle 1, ack in cycle k>=1, RESP in cycle k+1.
//    Zero-wait slave: 3 cycles, with the core stalled for 2.
//  - dbus_dat_i holds its last value outside RESP. A write does not modify rdata.
//  - wb_adr_o/wb_dat_o/wb_we_o hold their values until the next accept.
//  - wb_ack_i and wb_err_i outside BUS are ignored.
//  - Reset mid-operation (any state): next edge gives IDLE, cyc/stb=0, counter=0, rdata=0.
//    No response is delivered for the aborted access.
// STRUCTURE
//  - Package j1_wb_pkg: typedef enum logic [1:0] {IDLE,BUS,RESP} bridge_state_t; ERR_DATA constant.
//    Wishbone cycle-type constants live there too, shared with later peripherals.
//  - One sub-module: wb_timeout (TW-bit counter with clr/en inputs and an expired output at TIMEOUT).
//  - Datapath registers are adr, wdat, we, rdata and err. The FSM is a single always_ff with an always_comb for outputs.
// TESTING
//  1. Read, zero-wait slave returns 16'hBEEF.
//     Expect: cyc in cycle 1, stall high 2 cycles, dbus_dat_i=16'hBEEF in RESP, bus_err=0.
//  2. Write adr=16'h0040, dat=16'h1234, ack after 3 waits.
//     Expect: wb_we_o=1, wb_adr_o=16'h0040, wb_dat_o=16'h1234 stable across 4 BUS cycles, rdata unchanged.
//  3. Read to a silent slave, TIMEOUT=8.
//     Expect: abort after 8 BUS cycles, dbus_dat_i=16'hFFFF, bus_err pulse exactly 1 cycle.
//  4. wb_err_i and wb_ack_i in the same cycle.
//     Expect: ack wins, bus_err=0. wb_err_i alone: bus_err=1 and read data=16'hFFFF.
//  5. Back-to-back reads with re held through RESP.
//     Expect: exactly two Wishbone cycles, no duplicate issue. re&we together: a single write.
//  6. reset asserted mid-BUS.
//     Expect: next edge gives cyc=0, stall=0, dbus_dat_i=0. A later read completes normally.

Source files
------------

// File: rtl/j1_wb_pkg.sv
// Shared definitions for the J1 data-bus to Wishbone bridge and the peripherals behind it.
// Holds the bridge state type, the error read-back pattern and Wishbone cycle-type codes.
package j1_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    // Read data returned to the core when an access ends in wb_err_i or timeout.
    localparam logic [63:0] ERR_DATA = '1;

    // Wishbone B4 cycle-type identifiers (CTI_O) and burst-type extensions (BTE_O).
    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [2:0] WB_CTI_CONST   = 3'b001;
    localparam logic [2:0] WB_CTI_INCR    = 3'b010;
    localparam logic [2:0] WB_CTI_EOB     = 3'b111;

    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
    localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
    localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
    localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

    // A simultaneous re/we request is treated as a write.
    function automatic logic dbus_is_write(input logic re, input logic we);
        return we | (we & re);
    endfunction

    function automatic logic dbus_is_req(input logic re, input logic we);
        return re | we;
    endfunction

endpackage

// File: rtl/j1_dbus_wb_bridge_timeout.sv
// Bus-cycle watchdog for the bridge: counts cycles spent waiting on a slave.
// o_expired flags the TIMEOUT-th counted cycle so the bridge never waits longer than TIMEOUT cycles.
module wb_timeout #(
    parameter int TW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    output logic          o_expired,
    output logic [TW-1:0] o_count
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // r_count holds the cycles already completed, so the current one is the TIMEOUT-th at LAST.
    assign o_expired = i_en && (r_count == LAST);
    assign o_count   = r_count;

endmodule

// File: rtl/j1_dbus_wb_bridge.sv
// Converts J1 dbus re/we strobes into single Wishbone B4 classic cycles, stalling the core
// until ack, err or timeout and then presenting read data and an error pulse for one cycle.
module j1_dbus_wb_bridge
    import j1_wb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] dbus_adr,
    input  logic [DW-1:0] dbus_dat_o,
    input  logic          dbus_re,
    input  logic          dbus_we,
    output logic [DW-1:0] dbus_dat_i,
    output logic          stall,
    output logic          bus_err,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    output bridge_state_t o_dbg_state
);

    // Handshake: the core holds re/we while stall is high; a request is accepted on the
    // edge where the bridge is IDLE and re|we is high. Toward the slave, cyc/stb stay high
    // until the first edge with ack or err (or the watchdog), and that edge ends the cycle.

    bridge_state_t r_state;
    bridge_state_t w_state_nxt;

    logic [AW-1:0] r_adr;
    logic [DW-1:0] r_wdat;
    logic          r_we;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic          w_req;
    logic          w_accept;
    logic          w_in_bus;
    logic          w_expired;
    logic [TW-1:0] w_count;

    assign w_req    = dbus_is_req(dbus_re, dbus_we);
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_in_bus = (r_state == BUS);

    wb_timeout #(
        .TW      (TW),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_accept),
        .i_en      (w_in_bus),
        .o_expired (w_expired),
        .o_count   (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = BUS;
            BUS:     if (wb_ack_i || wb_err_i || w_expired) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_adr  <= dbus_adr;
                r_wdat <= dbus_dat_o;
                r_we   <= dbus_is_write(dbus_re, dbus_we);
                r_err  <= 1'b0;
            end else if (w_in_bus) begin
                // Ack beats err, err beats the watchdog; writes never touch r_rdata.
                if (wb_ack_i) begin
                    if (!r_we) r_rdata <= wb_dat_i;
                    r_err <= 1'b0;
                end else if (wb_err_i || w_expired) begin
                    if (!r_we) r_rdata <= ERR_DATA[DW-1:0];
                    r_err <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall       = 1'b0;
        wb_cyc_o    = 1'b0;
        bus_err     = 1'b0;
        case (r_state)
            IDLE:    stall = w_req;
            BUS: begin
                stall    = 1'b1;
                wb_cyc_o = 1'b1;
            end
            RESP:    bus_err = r_err;
            default: stall = 1'b0;
        endcase
        wb_stb_o    = wb_cyc_o;
        wb_we_o     = r_we;
        wb_adr_o    = r_adr;
        wb_dat_o    = r_wdat;
        dbus_dat_i  = r_rdata;
        o_dbg_state = r_state;
    end

    logic w_unused;
    assign w_unused = ^w_count;

endmodule

// File: tb/tb_j1_dbus_wb_bridge.sv
// Self-checking bench for j1_dbus_wb_bridge: the bench plays the Wishbone slave and predicts
// each access outcome (duration, error flag, read data) from the bridge's transfer rules.
module tb_j1_dbus_wb_bridge;
    import j1_wb_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 8;
    localparam int TW  = 8;

    localparam int K_ACK    = 0;
    localparam int K_ERR    = 1;
    localparam int K_SILENT = 2;
    localparam int K_BOTH   = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] dbus_adr;
    logic [DW-1:0] dbus_dat_o;
    logic          dbus_re;
    logic          dbus_we;
    logic [DW-1:0] dbus_dat_i;
    logic          stall;
    logic          bus_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    bridge_state_t dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc_starts = 0;
    logic cyc_prev = 1'b0;

    // Model: last read data the core saw, and the queue of expected responses {err, data}.
    logic [DW-1:0] m_rdata;
    logic [DW:0]   exp_q[$];

    j1_dbus_wb_bridge #(
        .AW(AW), .DW(DW), .TIMEOUT(TMO), .TW(TW)
    ) dut (
        .clk(clk), .reset(reset),
        .dbus_adr(dbus_adr), .dbus_dat_o(dbus_dat_o), .dbus_re(dbus_re), .dbus_we(dbus_we),
        .dbus_dat_i(dbus_dat_i), .stall(stall), .bus_err(bus_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wb_cyc_o && !cyc_prev) cyc_starts++;
        cyc_prev = wb_cyc_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- driver ----------------
    // Called just after a negedge with the bridge idle. Runs one complete access.
    task automatic run_access(input logic re, input logic we,
                              input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input int kind, input int waits, input bit hold);
        logic [DW-1:0] slv_dat;
        logic [DW:0]   exp;
        int            end_n;
        bit            exp_err;
        int            cyc0;
        slv_dat = DW'($urandom);
        if (kind != K_SILENT && waits + 1 <= TMO) begin
            end_n   = waits + 1;
            exp_err = (kind == K_ERR);
        end else begin
            end_n   = TMO;
            exp_err = 1'b1;
        end
        if (!we) m_rdata = exp_err ? 16'hFFFF : slv_dat;
        exp_q.push_back({exp_err, m_rdata});
        cyc0 = cyc_starts;

        dbus_adr   = adr;
        dbus_dat_o = dat;
        dbus_re    = re;
        dbus_we    = we;
        #1;
        check_eq("req_stall", 32'(stall), 32'd1);
        check_eq("req_no_cyc", 32'(wb_cyc_o), 32'd0);
        @(negedge clk);
        if (!hold) begin
            dbus_re    = 1'b0;
            dbus_we    = 1'b0;
            dbus_adr   = AW'($urandom);
            dbus_dat_o = DW'($urandom);
        end
        for (int n = 1; n <= end_n; n++) begin
            check_eq("bus_cyc", 32'(wb_cyc_o), 32'd1);
            check_eq("bus_stb", 32'(wb_stb_o), 32'd1);
            check_eq("bus_stall", 32'(stall), 32'd1);
            check_eq("bus_we", 32'(wb_we_o), 32'(we));
            check_eq("bus_adr", 32'(wb_adr_o), 32'(adr));
            if (we) check_eq("bus_wdat", 32'(wb_dat_o), 32'(dat));
            wb_ack_i = (n == waits + 1) && (kind == K_ACK || kind == K_BOTH);
            wb_err_i = (n == waits + 1) && (kind == K_ERR || kind == K_BOTH);
            wb_dat_i = (n == waits + 1) ? slv_dat : DW'($urandom);
            next_cycle();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
        end

        // Response cycle
        exp = exp_q.pop_front();
        check_eq("resp_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("resp_stall", 32'(stall), 32'd0);
        check_eq("resp_state", 32'(dbg_state), 32'(RESP));
        check_eq("resp_err", 32'(bus_err), 32'(exp[DW]));
        check_eq("resp_rdata", 32'(dbus_dat_i), 32'(exp[DW-1:0]));
        check_eq("resp_adr_hold", 32'(wb_adr_o), 32'(adr));
        check_eq("resp_we_hold", 32'(wb_we_o), 32'(we));
        check_eq("wb_cycles", 32'(cyc_starts - cyc0), 32'd1);
        next_cycle();
        check_eq("post_err", 32'(bus_err), 32'd0);
        check_eq("post_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("post_rdata", 32'(dbus_dat_i), 32'(exp[DW-1:0]));

        if (!hold) begin
            // Stray slave responses while idle must be ignored.
            wb_ack_i = 1'b1;
            wb_err_i = 1'b1;
            wb_dat_i = DW'($urandom);
            next_cycle();
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            check_eq("idle_cyc", 32'(wb_cyc_o), 32'd0);
            check_eq("idle_err", 32'(bus_err), 32'd0);
            check_eq("idle_rdata", 32'(dbus_dat_i), 32'(exp[DW-1:0]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset      = 1'b1;
        dbus_adr   = '0;
        dbus_dat_o = '0;
        dbus_re    = 1'b0;
        dbus_we    = 1'b0;
        wb_dat_i   = '0;
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        m_rdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("rst_stb", 32'(wb_stb_o), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_err", 32'(bus_err), 32'd0);
        check_eq("rst_rdata", 32'(dbus_dat_i), 32'd0);
        check_eq("rst_adr", 32'(wb_adr_o), 32'd0);
        check_eq("rst_we", 32'(wb_we_o), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        next_cycle();

        // Zero-wait read, waited write, silent slave, ack+err, err alone
        run_access(1'b1, 1'b0, 16'h0010, 16'h0000, K_ACK, 0, 1'b0);
        run_access(1'b0, 1'b1, 16'h0040, 16'h1234, K_ACK, 3, 1'b0);
        run_access(1'b1, 1'b0, 16'h0050, 16'h0000, K_SILENT, 0, 1'b0);
        run_access(1'b1, 1'b0, 16'h0060, 16'h0000, K_BOTH, 2, 1'b0);
        run_access(1'b1, 1'b0, 16'h0070, 16'h0000, K_ERR, 1, 1'b0);
        // Ack on the final allowed cycle beats the watchdog
        run_access(1'b1, 1'b0, 16'h0080, 16'h0000, K_ACK, TMO - 1, 1'b0);
        // Back-to-back reads with re held through RESP, then re&we as one write
        run_access(1'b1, 1'b0, 16'h0090, 16'h0000, K_ACK, 0, 1'b1);
        run_access(1'b1, 1'b0, 16'h0090, 16'h0000, K_ACK, 1, 1'b0);
        run_access(1'b1, 1'b1, 16'h00A0, 16'hCAFE, K_ACK, 0, 1'b0);

        // Reset in the middle of a bus cycle
        dbus_adr = 16'h00B0;
        dbus_re  = 1'b1;
        next_cycle();
        dbus_re = 1'b0;
        next_cycle();
        check_eq("mid_cyc_before", 32'(wb_cyc_o), 32'd1);
        reset = 1'b1;
        next_cycle();
        check_eq("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
        check_eq("mid_rst_stall", 32'(stall), 32'd0);
        check_eq("mid_rst_rdata", 32'(dbus_dat_i), 32'd0);
        check_eq("mid_rst_err", 32'(bus_err), 32'd0);
        reset   = 1'b0;
        m_rdata = '0;
        next_cycle();
        check_eq("mid_rst_idle", 32'(wb_cyc_o), 32'd0);
        run_access(1'b1, 1'b0, 16'h00C0, 16'h0000, K_ACK, 2, 1'b0);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            logic r_re;
            logic r_we;
            r_we = 1'($urandom_range(0, 1));
            r_re = r_we ? 1'($urandom_range(0, 1)) : 1'b1;
            run_access(r_re, r_we, AW'($urandom), DW'($urandom),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, TMO)),
                       1'($urandom_range(0, 3) == 0));
        end
        dbus_re = 1'b0;
        dbus_we = 1'b0;
        next_cycle();
        check_eq("final_idle", 32'(wb_cyc_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
